// File: rtl/proc_run_monitor.sv
// rtl/proc_run_monitor.sv - run controller with cycle count, done-edge capture and watchdog
module proc_run_monitor #(
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 4,
    parameter int CYC_W   = 16,
    parameter int TIMEOUT = 1000,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     proc_done,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [SEL_W-1:0]         rd_sel,
    output logic                     proc_run,
    output logic                     busy,
    output logic                     result_valid,
    output logic                     timed_out,
    output logic [CYC_W-1:0]         cycle_count,
    output logic [DATA_W-1:0]        rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        TOUT = 2'd3
    } state_t;

    state_t            state;
    logic              done_q;
    logic              done_edge;
    logic              at_limit;
    logic [DATA_W-1:0] snap [NUM_CH];

    assign done_edge = proc_done & ~done_q;
    assign at_limit  = (cycle_count == CYC_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            done_q       <= 1'b1;
            proc_run     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            timed_out    <= 1'b0;
            cycle_count  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                snap[k] <= '0;
            end
        end else begin
            result_valid <= 1'b0;
            // clear outranks start and a same-cycle done edge, so an aborted run never captures
            if (clear) begin
                state       <= IDLE;
                proc_run    <= 1'b0;
                busy        <= 1'b0;
                timed_out   <= 1'b0;
                cycle_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state       <= RUN;
                            proc_run    <= 1'b1;
                            busy        <= 1'b1;
                            cycle_count <= '0;
                            done_q      <= 1'b1;
                        end
                    end
                    RUN: begin
                        done_q <= proc_done;
                        if (done_edge) begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                snap[k] <= ch_data[k*DATA_W +: DATA_W];
                            end
                            state        <= DONE;
                            proc_run     <= 1'b0;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                        end else if (at_limit) begin
                            state     <= TOUT;
                            proc_run  <= 1'b0;
                            busy      <= 1'b0;
                            timed_out <= 1'b1;
                        end else begin
                            cycle_count <= cycle_count + CYC_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_sel) < NUM_CH) begin
            rd_data = snap[rd_sel];
        end
    end

endmodule
